// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// data-memory freeze with a timeout error, plus a saturating stall counter.
module hazard_control_unit #(
    parameter int unsigned MEM_TIMEOUT         = 16,
    parameter int unsigned STALL_COUNTER_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [4:0]                     ID_read_register_0,
    input  logic [4:0]                     ID_read_register_1,
    input  logic                           ID_uses_register_0,
    input  logic                           ID_uses_register_1,
    input  logic                           EX_mem_read_enable,
    input  logic [4:0]                     EX_destination_register,
    input  logic                           EX_branch_taken,
    input  logic                           MEM_mem_access,
    input  logic                           MEM_mem_ready,
    output logic                           pc_write_enable,
    output logic                           IF_ID_write_enable,
    output logic                           IF_ID_flush,
    output logic                           ID_EX_write_enable,
    output logic                           ID_EX_flush,
    output logic                           EX_MEM_write_enable,
    output logic                           mem_timeout_error,
    output logic [STALL_COUNTER_WIDTH-1:0] stall_count
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
    // Counter value held during the last frozen cycle an access may take.
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StError
    } state_e;

    state_e                         state_q, state_d;
    logic [WaitW-1:0]               wait_cnt_q, wait_cnt_d;
    logic                           err_q, err_d;
    logic [STALL_COUNTER_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_stall;
    logic load_use;
    logic rs0_hit;
    logic rs1_hit;

    assign mem_stall = MEM_mem_access && !MEM_mem_ready;
    assign rs0_hit   = ID_uses_register_0 && (ID_read_register_0 == EX_destination_register);
    assign rs1_hit   = ID_uses_register_1 && (ID_read_register_1 == EX_destination_register);
    // x0 is never a real dependency.
    assign load_use  = EX_mem_read_enable && (EX_destination_register != 5'd0) &&
                       (rs0_hit || rs1_hit);

    // Pipeline control outputs, highest-priority condition first.
    always_comb begin
        pc_write_enable     = 1'b1;
        IF_ID_write_enable  = 1'b1;
        IF_ID_flush         = 1'b0;
        ID_EX_write_enable  = 1'b1;
        ID_EX_flush         = 1'b0;
        EX_MEM_write_enable = 1'b1;
        if (rst) begin
            pc_write_enable     = 1'b0;
            IF_ID_write_enable  = 1'b0;
            ID_EX_write_enable  = 1'b0;
            EX_MEM_write_enable = 1'b0;
            IF_ID_flush         = 1'b1;
            ID_EX_flush         = 1'b1;
        end else if (state_q == StError || mem_stall) begin
            // Freeze: branch/load-use inputs stay stable and are acted on afterwards.
            pc_write_enable     = 1'b0;
            IF_ID_write_enable  = 1'b0;
            ID_EX_write_enable  = 1'b0;
            EX_MEM_write_enable = 1'b0;
        end else if (EX_branch_taken) begin
            // The dependent instruction (if any) is squashed, so no bubble needed.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (load_use) begin
            pc_write_enable    = 1'b0;
            IF_ID_write_enable = 1'b0;
            ID_EX_flush        = 1'b1;
        end
    end

    // Freeze tracking FSM and stall counter next state.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            StRun: begin
                if (mem_stall) begin
                    // A one-cycle budget is exhausted by this very cycle.
                    if (MEM_TIMEOUT <= 1) begin
                        state_d = StError;
                    end else begin
                        state_d    = StMemWait;
                        wait_cnt_d = WaitW'(1);
                    end
                end
            end
            StMemWait: begin
                if (!mem_stall) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d = StError;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
        err_d = (state_d == StError);
        if (!pc_write_enable && (stall_cnt_q != {STALL_COUNTER_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_COUNTER_WIDTH'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_timeout_error = err_q;
    assign stall_count       = stall_cnt_q;

endmodule
